// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: loads a serial configuration flop chain from a word stream.
// Words arrive over a valid/ready handshake and are shifted LSB-first onto the
// chain head. After CHAIN_LEN shifts, cfg_e is pulsed for CFGE_CYCLES cycles,
// after which cfg_done is held until the next start or abort.
//
// Ports:
//   CK, RSTN          clock, asynchronous active-low reset
//   start, abort      load request (IDLE/DONE only), synchronous abort to IDLE
//   in_valid/in_data  bitstream word input, bit 0 shifted first
//   in_ready          word accepted this cycle (combinational from registered state)
//   sc_se, sc_si      chain shift enable and serial data (sc_si=0 when sc_se=0)
//   cfg_e, cfg_done   configure enable (LATCH), configuration complete (DONE)
//   busy              high in LOAD and LATCH
module cfg_chain_loader #(
  parameter int unsigned CHAIN_LEN   = 64,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CFGE_CYCLES = 2
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sc_se,
  output logic              sc_si,
  output logic              cfg_e,
  output logic              cfg_done,
  output logic              busy
);

  localparam int unsigned REM_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned CFGE_W = $clog2(CFGE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LATCH,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [REM_W-1:0]    rem_q, rem_d;     // chain bits not yet scheduled for shifting
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // buffered bits waiting behind the one on sc_si
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [CFGE_W-1:0]   cfge_q, cfge_d;
  logic                sc_se_q, sc_se_d;
  logic                sc_si_q, sc_si_d;
  logic                cfg_e_q, cfg_e_d;
  logic                cfg_done_q, cfg_done_d;
  logic                busy_q, busy_d;
  logic                ready_c;
  logic                accept_c;
  logic [31:0]         take_c;

  // Ready once the buffer has drained (its last bit is on the wire now) and
  // the chain still needs bits beyond those already buffered.
  assign ready_c  = (state_q == ST_LOAD) && (cnt_q == '0) &&
                    (32'(rem_q) > 32'(cnt_q));
  assign accept_c = in_valid && ready_c;

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    cfge_d  = cfge_q;
    sc_se_d = 1'b0;
    sc_si_d = 1'b0;
    take_c  = 32'd0;

    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      cnt_d   = '0;
      buf_d   = '0;
      cfge_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_LOAD;
            rem_d   = REM_W'(CHAIN_LEN);
            cnt_d   = '0;
            buf_d   = '0;
          end
        end
        ST_LOAD: begin
          if (rem_q == '0) begin
            state_d = ST_LATCH;
            cfge_d  = CFGE_W'(CFGE_CYCLES - 1);
          end else if (cnt_q != '0) begin
            sc_se_d = 1'b1;
            sc_si_d = buf_q[0];
            buf_d   = buf_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            rem_d   = rem_q - REM_W'(1);
          end else if (accept_c) begin
            // Only the low rem bits of a final partial word are kept.
            take_c  = (32'(rem_q) < DATA_W) ? 32'(rem_q) : DATA_W;
            sc_se_d = 1'b1;
            sc_si_d = in_data[0];
            buf_d   = in_data >> 1;
            cnt_d   = CNT_W'(take_c - 32'd1);
            rem_d   = rem_q - REM_W'(1);
          end
        end
        ST_LATCH: begin
          if (cfge_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cfge_d = cfge_q - CFGE_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cfg_e_d    = (state_d == ST_LATCH);
    cfg_done_d = (state_d == ST_DONE);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_LATCH);
  end

  // State and output registers.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      cfge_q     <= '0;
      sc_se_q    <= 1'b0;
      sc_si_q    <= 1'b0;
      cfg_e_q    <= 1'b0;
      cfg_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      cfge_q     <= cfge_d;
      sc_se_q    <= sc_se_d;
      sc_si_q    <= sc_si_d;
      cfg_e_q    <= cfg_e_d;
      cfg_done_q <= cfg_done_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = ready_c;
  assign sc_se    = sc_se_q;
  assign sc_si    = sc_si_q;
  assign cfg_e    = cfg_e_q;
  assign cfg_done = cfg_done_q;
  assign busy     = busy_q;

endmodule
